mc_control_fsm: RTL and testbench

Multicycle control unit for the RV-MC core: a Moore state machine that sequences each RV32I instruction through fetch, decode, execute, memory and writeback. It produces the select lines consumed by the datapath's `mux2`/`mux3` instances, plus the register, memory and PC write enables.

---
 rtl/rv_mc_pkg.sv | 61 ++++++
 rtl/alu_decoder.sv | 31 +++
 rtl/mc_control_fsm.sv | 139 +++++++++++++
 tb/tb_mc_control_fsm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mc_pkg.sv
// Shared encodings for the RV-MC multicycle control unit: FSM states, opcodes and
// datapath select-line values.
package rv_mc_pkg;

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecuteR = 4'd6;
  localparam logic [3:0] StExecuteI = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBeq      = 4'd9;
  localparam logic [3:0] StJal      = 4'd10;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  // Unknown opcodes fall back to the I-type immediate format.
  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    case (op)
      OpStore: imm_decode = ImmS;
      OpBeq:   imm_decode = ImmB;
      OpJal:   imm_decode = ImmJ;
      default: imm_decode = ImmI;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction funct fields onto the ALU control code.
module alu_decoder
  import rv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluAdd;
    case (alu_op)
      AluOpAdd: alu_control = AluAdd;
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        case (funct3)
          // Only R-type SUB subtracts; ADDI with instr[30] set is still an add.
          3'b000:  alu_control = (funct7b5 && op5) ? AluSub : AluAdd;
          3'b010:  alu_control = AluSlt;
          3'b110:  alu_control = AluOr;
          3'b111:  alu_control = AluAnd;
          default: alu_control = AluAdd;
        endcase
      end
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the RV-MC multicycle core: sequences fetch, decode, execute,
// memory and writeback, driving datapath selects and write enables.
module mc_control_fsm
  import rv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control
);

  logic [3:0] state_q, state_d;
  logic [3:0] out_state;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StJal:      state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // During reset the outputs look like FETCH, with every write enable suppressed below.
  assign out_state = reset ? StFetch : state_q;

  always_comb begin
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRs2;
    reg_write  = 1'b0;
    alu_op     = AluOpAdd;
    pc_update  = 1'b0;
    branch     = 1'b0;
    case (out_state)
      StFetch: begin
        ir_write   = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        pc_update  = 1'b1;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SrcARs1;
        alu_op    = AluOpFunct;
      end
      StExecuteI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunct;
      end
      StAluWb: reg_write = 1'b1;
      StBeq: begin
        alu_src_a = SrcARs1;
        alu_op    = AluOpSub;
        branch    = 1'b1;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign pc_write = ~reset & (pc_update | (branch & zero));
  assign imm_src  = imm_decode(op);

  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alu_control(alu_control)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through the FSM and
// compares the packed control outputs against hand-computed per-cycle values.
module tb_mc_control_fsm;

  logic       clk, reset, funct7b5, zero;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  int checks = 0;
  int errors = 0;

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, reg_write, alu_control}
  localparam logic [13:0] E_FETCH    = {4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000};
  localparam logic [13:0] E_RST      = {4'b0000, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000};
  localparam logic [13:0] E_DECODE   = {4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 3'b000};
  localparam logic [13:0] E_MEMADR   = {4'b0000, 2'b00, 2'b10, 2'b01, 1'b0, 3'b000};
  localparam logic [13:0] E_MEMREAD  = {4'b0100, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
  localparam logic [13:0] E_MEMWB    = {4'b0000, 2'b01, 2'b00, 2'b00, 1'b1, 3'b000};
  localparam logic [13:0] E_MEMWRITE = {4'b0110, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
  localparam logic [13:0] E_ALUWB    = {4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000};
  localparam logic [13:0] E_JAL      = {4'b1000, 2'b00, 2'b01, 2'b10, 1'b0, 3'b000};
  localparam logic [13:0] E_EXR_SUB  = {4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, 3'b001};
  localparam logic [13:0] E_EXI_ADD  = {4'b0000, 2'b00, 2'b10, 2'b01, 1'b0, 3'b000};
  localparam logic [13:0] E_BEQ_T    = {4'b1000, 2'b00, 2'b10, 2'b00, 1'b0, 3'b001};
  localparam logic [13:0] E_BEQ_NT   = {4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, 3'b001};

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .imm_src    (imm_src),
    .alu_control(alu_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] outs();
    return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
            reg_write, alu_control};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] exp [4];
    exp = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWRITE};
    reset = 1'b1;
    op = 7'b0100011;
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL reset_sw cycle %0d: got %b want %b", i, outs(), exp[i]);
      end
    end
    checks++;
    if (imm_src !== 2'b01) begin
      errors++;
      $display("FAIL imm_sw: got %b want 01", imm_src);
    end
    // Abort the store while it sits in MEMWRITE.
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      checks++;
      if (outs() !== E_RST) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", i, outs(), E_RST);
      end
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== E_FETCH) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", outs(), E_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [13:0] exp [5];
    exp = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB};
    op = 7'b0000011;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL lw cycle %0d: got %b want %b", i, outs(), exp[i]);
      end
    end
    tick();
  endtask

  task automatic test_sub_addi();
    logic [13:0] exp [8];
    exp = '{E_FETCH, E_DECODE, E_EXR_SUB, E_ALUWB, E_FETCH, E_DECODE, E_EXI_ADD, E_ALUWB};
    op = 7'b0110011;
    funct3 = 3'b000;
    funct7b5 = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        op = 7'b0010011;
        #1;
      end
      if (i > 0 && i != 4) tick();
      if (i == 4) tick();
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL sub_addi cycle %0d: got %b want %b", i, outs(), exp[i]);
      end
    end
    tick();
  endtask

  task automatic test_alu_funct();
    logic [2:0] f3 [4];
    logic [2:0] want [4];
    f3 = '{3'b010, 3'b110, 3'b111, 3'b100};
    want = '{3'b101, 3'b011, 3'b010, 3'b000};
    op = 7'b0010011;
    funct7b5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      funct3 = f3[i];
      tick();
      tick();
      checks++;
      if (alu_control !== want[i] || alu_src_b !== 2'b01) begin
        errors++;
        $display("FAIL alu_funct f3=%b: got ctrl %b srcb %b want ctrl %b srcb 01", f3[i],
                 alu_control, alu_src_b, want[i]);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_beq();
    logic [13:0] exp [4];
    op = 7'b1100011;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      exp = '{E_FETCH, E_DECODE, (z == 1) ? E_BEQ_T : E_BEQ_NT, E_FETCH};
      #1;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        checks++;
        if (outs() !== exp[i]) begin
          errors++;
          $display("FAIL beq zero=%0d cycle %0d: got %b want %b", z, i, outs(), exp[i]);
        end
        if (i == 2) begin
          checks++;
          if (imm_src !== 2'b10) begin
            errors++;
            $display("FAIL imm_beq: got %b want 10", imm_src);
          end
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [13:0] exp [5];
    exp = '{E_FETCH, E_DECODE, E_JAL, E_ALUWB, E_FETCH};
    op = 7'b1101111;
    #1;
    checks++;
    if (imm_src !== 2'b11) begin
      errors++;
      $display("FAIL imm_jal: got %b want 11", imm_src);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL jal cycle %0d: got %b want %b", i, outs(), exp[i]);
      end
    end
  endtask

  task automatic test_unknown();
    logic [13:0] exp [3];
    exp = '{E_FETCH, E_DECODE, E_FETCH};
    op = 7'b1111111;
    zero = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      checks++;
      if (outs() !== exp[i] || imm_src !== 2'b00) begin
        errors++;
        $display("FAIL unknown cycle %0d: got %b imm %b want %b imm 00", i, outs(), imm_src,
                 exp[i]);
      end
    end
    zero = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    op = 7'b0;
    funct3 = 3'b0;
    funct7b5 = 1'b0;
    zero = 1'b0;
    test_reset();
    test_lw();
    test_sub_addi();
    test_alu_funct();
    test_beq();
    test_jal();
    test_unknown();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
